pulse_receiver: RTL

PULSE_RECEIVER -- requirements
Module: pulse_receiver

---
 rtl/pulse_pkg.sv | 19 +
 rtl/pulse_bit_counter.sv | 48 ++++
 rtl/pulse_receiver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// ============================================================================
// Module  : pulse_pkg
// Purpose : Shared word width and FSM state encoding for the pulse link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_pkg;

  localparam int unsigned WIDTH = 16;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_RECEIVE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pulse_bit_counter.sv
// ============================================================================
// Module  : pulse_bit_counter
// Purpose : Bit position counter with increment, clear and terminal count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_bit_counter
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = pulse_pkg::WIDTH,
  localparam int unsigned CW   = $clog2(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over increment so a completed word always restarts at zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/pulse_receiver.sv
// ============================================================================
// Module  : pulse_receiver
// Purpose : Serial-to-parallel word receiver with valid/ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_receiver
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = pulse_pkg::WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     frame_flag,
  input  logic                     word_ack,
  output logic [WIDTH-1:0]         out_word,
  output logic                     word_valid,
  output logic                     frame_error,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t state_q;
  state_t state_d;

  // Only WIDTH-1 bits are stored; the final bit goes straight into out_word.
  logic [WIDTH-2:0] shift_q;
  logic [WIDTH-2:0] shift_d;
  logic [WIDTH-1:0] out_word_q;
  logic [WIDTH-1:0] out_word_d;
  logic             valid_q;
  logic             valid_d;
  logic             ferr_q;
  logic             ferr_d;
  logic             ovr_q;
  logic             ovr_d;

  logic [CW-1:0]    cnt;
  logic             cnt_tc;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             complete;
  logic             abort;

  pulse_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk_i   (clock),
    .rst_i   (reset),
    .inc_i   (cnt_inc),
    .clr_i   (cnt_clr),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame_flag)  state_d = ST_RECEIVE;
      ST_RECEIVE: if (!frame_flag) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Terminal count is only reachable in RECEIVE since IDLE always holds zero.
  always_comb begin
    complete = 1'b0;
    abort    = 1'b0;
    if (state_q == ST_RECEIVE) begin
      complete = frame_flag & cnt_tc;
      abort    = ~frame_flag & (cnt != '0);
    end
    cnt_inc = frame_flag & ~complete;
    cnt_clr = ~frame_flag | complete;
  end

  always_comb begin
    shift_d    = frame_flag ? {shift_q[WIDTH-3:0], serial_in} : shift_q;
    out_word_d = complete ? {shift_q, serial_in} : out_word_q;
    valid_d    = complete ? 1'b1 : (word_ack ? 1'b0 : valid_q);
    ovr_d      = ovr_q | (complete & valid_q & ~word_ack);
    ferr_d     = abort;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= '0;
      out_word_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      out_word_q <= out_word_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_word    = out_word_q;
  assign word_valid  = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign bit_count   = cnt;

endmodule

`default_nettype wire
